// File: rtl/multiboot_pkg.sv
// Shared constants and state type for the multiboot control stage.
// Port addresses, register offsets, unlock/trigger codes, FSM states.
package multiboot_pkg;

    localparam logic [15:0] INDEX_PORT = 16'hFC3B;
    localparam logic [15:0] DATA_PORT  = 16'hFD3B;

    localparam logic [7:0] OFS_ADDR_L = 8'd0;
    localparam logic [7:0] OFS_ADDR_M = 8'd1;
    localparam logic [7:0] OFS_ADDR_H = 8'd2;
    localparam logic [7:0] OFS_CTRL   = 8'd3;

    localparam logic [7:0] UNLOCK_CODE  = 8'h5A;
    localparam logic [7:0] TRIGGER_CODE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PULSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/multiboot_sync_edge.sv
// Two-flop synchroniser with a rising-edge detector on the synced level.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~prev;

endmodule

// File: rtl/multiboot_ctrl.sv
// Z80-facing boot address / reboot request stage for the ICAP sequencer.
// Optional readback path: define MULTIBOOT_READBACK_EN.
module multiboot_ctrl
    import multiboot_pkg::*;
#(
    parameter logic [23:0] DEFAULT_ADDR   = 24'h058000,
    parameter logic [7:0]  REG_BASE       = 8'h40,
    parameter int          PULSE_LEN      = 8,
    parameter int          UNLOCK_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d_in,
    output logic [7:0]  cpu_d_out,
    output logic        cpu_d_oe,
    input  logic        cpu_iorq_n,
    input  logic        cpu_wr_n,
    input  logic        cpu_rd_n,
    input  logic        key_reboot,
    output logic [23:0] spi_addr,
    output logic        REBOOT,
    output logic        busy
);

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);
    localparam logic [7:0] TMO_LAST   = 8'(UNLOCK_TIMEOUT - 1);

    state_t     state;
    state_t     next;
    logic [7:0] cnt;
    logic [7:0] index;

    logic unused_wr_lvl;
    logic unused_key_lvl;
    logic wr_ev;
    logic key_rise;

    sync_edge u_wr (
        .clk   (CLK),
        .rst   (RESET),
        .din   (~cpu_iorq_n & ~cpu_wr_n),
        .level (unused_wr_lvl),
        .rise  (wr_ev)
    );

    sync_edge u_key (
        .clk   (CLK),
        .rst   (RESET),
        .din   (key_reboot),
        .level (unused_key_lvl),
        .rise  (key_rise)
    );

    logic live;
    logic idx_wr;
    logic data_wr;
    logic sel_l, sel_m, sel_h, sel_c;
    logic ctrl_wr;
    logic key_ev;
    logic addr_wr;

    assign live    = (state != DONE);
    assign idx_wr  = wr_ev & live & (cpu_a == INDEX_PORT);
    assign data_wr = wr_ev & live & (cpu_a == DATA_PORT);
    assign sel_l   = (index == REG_BASE + OFS_ADDR_L);
    assign sel_m   = (index == REG_BASE + OFS_ADDR_M);
    assign sel_h   = (index == REG_BASE + OFS_ADDR_H);
    assign sel_c   = (index == REG_BASE + OFS_CTRL);
    assign ctrl_wr = data_wr & sel_c;
    assign key_ev  = key_rise & ((state == IDLE) | (state == ARMED));
    assign addr_wr = data_wr & (state == IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= next;
            if (next != state)
                cnt <= 8'd0;
            else if (state == ARMED || state == PULSE)
                cnt <= cnt + 8'd1;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (key_ev)
                    next = PULSE;
                else if (ctrl_wr && cpu_d_in == UNLOCK_CODE)
                    next = ARMED;
            end
            ARMED: begin
                if (key_ev)
                    next = PULSE;
                else if (ctrl_wr)
                    next = (cpu_d_in == TRIGGER_CODE) ? PULSE : IDLE;
                else if (cnt == TMO_LAST)
                    next = IDLE;
            end
            PULSE: begin
                if (cnt == PULSE_LAST)
                    next = DONE;
            end
            DONE: next = DONE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        REBOOT = (state == PULSE);
        busy   = (state != IDLE);
    end

    // Hotkey overrides any address write landing in the same cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            spi_addr <= DEFAULT_ADDR;
            index    <= 8'h00;
        end else begin
            if (idx_wr)
                index <= cpu_d_in;
            if (key_ev)
                spi_addr <= DEFAULT_ADDR;
            else if (addr_wr) begin
                if (sel_l) spi_addr[7:0]   <= cpu_d_in;
                if (sel_m) spi_addr[15:8]  <= cpu_d_in;
                if (sel_h) spi_addr[23:16] <= cpu_d_in;
            end
        end
    end

`ifdef MULTIBOOT_READBACK_EN
    logic       rd_lvl;
    logic       rd_rise;
    logic       rd_hit;
    logic [7:0] rdata;

    sync_edge u_rd (
        .clk   (CLK),
        .rst   (RESET),
        .din   (~cpu_iorq_n & ~cpu_rd_n),
        .level (rd_lvl),
        .rise  (rd_rise)
    );

    assign rd_hit = (cpu_a == DATA_PORT) | (cpu_a == INDEX_PORT);

    always_comb begin
        rdata = 8'hFF;
        unique case (1'b1)
            (cpu_a == INDEX_PORT): rdata = index;
            sel_l: rdata = spi_addr[7:0];
            sel_m: rdata = spi_addr[15:8];
            sel_h: rdata = spi_addr[23:16];
            sel_c: rdata = {5'b0, state == DONE,
                            state == PULSE, state == ARMED};
            default: rdata = 8'hFF;
        endcase
    end

    // Data is captured once per read and held while the CPU samples it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cpu_d_oe  <= 1'b0;
            cpu_d_out <= 8'h00;
        end else begin
            cpu_d_oe <= rd_lvl & rd_hit;
            if (rd_rise & rd_hit)
                cpu_d_out <= rdata;
        end
    end
`else
    logic unused_rd;
    assign unused_rd = cpu_rd_n;
    assign cpu_d_oe  = 1'b0;
    assign cpu_d_out = 8'h00;
`endif

endmodule

// File: tb/tb_multiboot_ctrl.sv
// Directed plus randomized self-checking bench for multiboot_ctrl.
module tb_multiboot_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] cpu_a = 16'h0000;
    logic [7:0]  cpu_d_in = 8'h00;
    logic [7:0]  cpu_d_out;
    logic        cpu_d_oe;
    logic        cpu_iorq_n = 1'b1;
    logic        cpu_wr_n = 1'b1;
    logic        cpu_rd_n = 1'b1;
    logic        key_reboot = 1'b0;
    logic [23:0] spi_addr;
    logic        REBOOT;
    logic        busy;

    localparam logic [23:0] DEF = 24'h058000;
    localparam logic [15:0] IXP = 16'hFC3B;
    localparam logic [15:0] DTP = 16'hFD3B;

    multiboot_ctrl dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .cpu_a      (cpu_a),
        .cpu_d_in   (cpu_d_in),
        .cpu_d_out  (cpu_d_out),
        .cpu_d_oe   (cpu_d_oe),
        .cpu_iorq_n (cpu_iorq_n),
        .cpu_wr_n   (cpu_wr_n),
        .cpu_rd_n   (cpu_rd_n),
        .key_reboot (key_reboot),
        .spi_addr   (spi_addr),
        .REBOOT     (REBOOT),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    int          hi_cycles = 0;
    int          rises = 0;
    int          addr_bad = 0;
    logic        prev_reb = 1'b0;
    logic [23:0] mon_exp = DEF;

    always @(negedge CLK) begin
        if (REBOOT === 1'b1) begin
            hi_cycles <= hi_cycles + 1;
            if (spi_addr !== mon_exp)
                addr_bad <= addr_bad + 1;
        end
        if (REBOOT === 1'b1 && prev_reb === 1'b0)
            rises <= rises + 1;
        prev_reb <= REBOOT;
    end

    logic [7:0] mbytes [3];
    int h0, r0, b0;

    function automatic logic [23:0] model_addr();
        return {mbytes[2], mbytes[1], mbytes[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        mbytes[0] = DEF[7:0];
        mbytes[1] = DEF[15:8];
        mbytes[2] = DEF[23:16];
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d,
                             input logic key);
        @(negedge CLK);
        cpu_a = a;
        cpu_d_in = d;
        cpu_iorq_n = 1'b0;
        cpu_wr_n = 1'b0;
        if (key) key_reboot = 1'b1;
        repeat (4) @(negedge CLK);
        cpu_iorq_n = 1'b1;
        cpu_wr_n = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic set_reg(input logic [7:0] idx, input logic [7:0] v);
        cpu_write(IXP, idx, 1'b0);
        cpu_write(DTP, v, 1'b0);
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d,
                            output logic oe);
        @(negedge CLK);
        cpu_a = a;
        cpu_iorq_n = 1'b0;
        cpu_rd_n = 1'b0;
        repeat (4) @(negedge CLK);
        d = cpu_d_out;
        oe = cpu_d_oe;
        cpu_iorq_n = 1'b1;
        cpu_rd_n = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic snap();
        h0 = hi_cycles;
        r0 = rises;
        b0 = addr_bad;
    endtask

    task automatic chk_pulse(input string tag, input int n_rise,
                             input int n_hi);
        chk({tag, "_rises"}, 32'(rises - r0), 32'(n_rise));
        chk({tag, "_hi"}, 32'(hi_cycles - h0), 32'(n_hi));
        chk({tag, "_addr"}, 32'(addr_bad - b0), 32'd0);
    endtask

    logic [7:0]  rd_d;
    logic        rd_oe;
    logic [23:0] ra;
    logic [7:0]  v;
    int          k;
    bit          got;

    initial begin
        mbytes[0] = DEF[7:0];
        mbytes[1] = DEF[15:8];
        mbytes[2] = DEF[23:16];
        repeat (3) @(negedge CLK);
        chk("rst_addr_async", 32'(spi_addr), 32'(DEF));
        chk("rst_reboot", 32'(REBOOT), 32'd0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_oe", 32'(cpu_d_oe), 32'd0);
        chk("rst_dout", 32'(cpu_d_out), 32'd0);

`ifdef MULTIBOOT_READBACK_EN
        cpu_write(IXP, 8'h40, 1'b0);
        cpu_read(DTP, rd_d, rd_oe);
        chk("rb_l", 32'(rd_d), 32'h00);
        chk("rb_oe", 32'(rd_oe), 32'd1);
        cpu_write(IXP, 8'h41, 1'b0);
        cpu_read(DTP, rd_d, rd_oe);
        chk("rb_m", 32'(rd_d), 32'h80);
        cpu_write(IXP, 8'h42, 1'b0);
        cpu_read(DTP, rd_d, rd_oe);
        chk("rb_h", 32'(rd_d), 32'h05);
        cpu_read(IXP, rd_d, rd_oe);
        chk("rb_index", 32'(rd_d), 32'h42);
        cpu_write(IXP, 8'h17, 1'b0);
        cpu_read(DTP, rd_d, rd_oe);
        chk("rb_other", 32'(rd_d), 32'hFF);
        chk("rb_oe_idle", 32'(cpu_d_oe), 32'd0);
`else
        cpu_read(DTP, rd_d, rd_oe);
        chk("nrb_oe", 32'(rd_oe), 32'd0);
        chk("nrb_dout", 32'(rd_d), 32'd0);
`endif

        // Randomized address programming with junk writes mixed in.
        for (int it = 0; it < 6; it++) begin
            ra = 24'($urandom);
            k = $urandom_range(0, 2);
            for (int j = 0; j < 3; j++) begin
                int b;
                b = (k + j) % 3;
                set_reg(8'(8'h40 + b), ra[8*b +: 8]);
                mbytes[b] = ra[8*b +: 8];
            end
            set_reg(8'(8'h44 + $urandom_range(0, 60)), 8'($urandom));
            cpu_write(16'h1234 + 16'(it), 8'($urandom), 1'b0);
            chk("rnd_addr", 32'(spi_addr), 32'(model_addr()));
            v = 8'($urandom);
            if (v == 8'h5A) v = 8'h5B;
            set_reg(8'h43, v);
            chk("rnd_ctrl_busy", 32'(busy), 32'd0);
        end

        // Unlock, ignored ARMED address write, trigger.
        set_reg(8'h40, 8'h00);
        set_reg(8'h41, 8'h00);
        set_reg(8'h42, 8'h0B);
        mbytes[0] = 8'h00; mbytes[1] = 8'h00; mbytes[2] = 8'h0B;
        chk("prog_addr", 32'(spi_addr), 32'h0B0000);
        set_reg(8'h43, 8'h5A);
        chk("armed_busy", 32'(busy), 32'd1);
`ifdef MULTIBOOT_READBACK_EN
        cpu_read(DTP, rd_d, rd_oe);
        chk("rb_ctrl_armed", 32'(rd_d), 32'h01);
`endif
        set_reg(8'h40, 8'h77);
        chk("armed_addr_ign", 32'(spi_addr), 32'(model_addr()));
        chk("armed_kept", 32'(busy), 32'd1);
        mon_exp = model_addr();
        snap();
        cpu_write(IXP, 8'h43, 1'b0);
        cpu_write(DTP, 8'hA5, 1'b0);
        repeat (12) @(negedge CLK);
        chk_pulse("trig", 1, 8);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_reboot", 32'(REBOOT), 32'd0);
        set_reg(8'h40, 8'hEE);
        set_reg(8'h43, 8'h5A);
        set_reg(8'h43, 8'hA5);
        cpu_write(DTP, 8'hA5, 1'b1);
        key_reboot = 1'b0;
        repeat (12) @(negedge CLK);
        chk_pulse("done_ign", 1, 8);
        chk("done_addr", 32'(spi_addr), 32'h0B0000);

        // Unlock timeout.
        do_reset();
        snap();
        set_reg(8'h43, 8'h5A);
        chk("tmo_busy_early", 32'(busy), 32'd1);
        repeat (200) @(negedge CLK);
        chk("tmo_busy_mid", 32'(busy), 32'd1);
        repeat (56) @(negedge CLK);
        chk("tmo_busy_after", 32'(busy), 32'd0);
        cpu_write(DTP, 8'hA5, 1'b0);
        repeat (12) @(negedge CLK);
        chk_pulse("tmo", 0, 0);
        chk("tmo_idle", 32'(busy), 32'd0);

        // Wrong code cancels ARMED.
        set_reg(8'h43, 8'h5A);
        chk("cancel_armed", 32'(busy), 32'd1);
        cpu_write(DTP, 8'h33, 1'b0);
        chk("cancel_idle", 32'(busy), 32'd0);
        cpu_write(DTP, 8'hA5, 1'b0);
        repeat (12) @(negedge CLK);
        chk_pulse("cancel", 0, 0);

        // Hotkey coincident with trigger: default address wins.
        set_reg(8'h40, 8'h00);
        set_reg(8'h41, 8'h80);
        set_reg(8'h42, 8'h09);
        chk("key_pre_addr", 32'(spi_addr), 32'h098000);
        set_reg(8'h43, 8'h5A);
        mon_exp = DEF;
        snap();
        cpu_write(DTP, 8'hA5, 1'b1);
        key_reboot = 1'b0;
        repeat (12) @(negedge CLK);
        chk_pulse("key_trig", 1, 8);
        chk("key_addr", 32'(spi_addr), 32'(DEF));

        // Hotkey from IDLE after random address.
        do_reset();
        ra = 24'($urandom);
        set_reg(8'h40, ra[7:0]);
        set_reg(8'h42, ra[23:16]);
        mbytes[0] = ra[7:0]; mbytes[2] = ra[23:16];
        chk("key_idle_pre", 32'(spi_addr), 32'(model_addr()));
        snap();
        @(negedge CLK);
        key_reboot = 1'b1;
        repeat (14) @(negedge CLK);
        key_reboot = 1'b0;
        chk_pulse("key_idle", 1, 8);
        chk("key_idle_addr", 32'(spi_addr), 32'(DEF));

        // Reset during the third PULSE cycle.
        do_reset();
        set_reg(8'h41, 8'h12);
        set_reg(8'h43, 8'h5A);
        @(negedge CLK);
        cpu_d_in = 8'hA5;
        cpu_iorq_n = 1'b0;
        cpu_wr_n = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge CLK);
            if (REBOOT === 1'b1) got = 1'b1;
        end
        chk("mid_seen", 32'(got), 32'd1);
        repeat (2) @(negedge CLK);
        chk("mid_high", 32'(REBOOT), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        chk("mid_reboot", 32'(REBOOT), 32'd0);
        chk("mid_addr", 32'(spi_addr), 32'(DEF));
        chk("mid_busy", 32'(busy), 32'd0);
        cpu_iorq_n = 1'b1;
        cpu_wr_n = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        repeat (4) @(negedge CLK);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_reboot", 32'(REBOOT), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiboot_ctrl.md
Name: multiboot_ctrl

Overview:
- CPU-facing control stage directly upstream of the multiboot/ICAP sequencer.
- Holds a 24-bit SPI flash boot address in three Z80-accessible registers behind the ZX-Uno style index/data ports (0xFC3B/0xFD3B).
- Requires an unlock-then-trigger write sequence, or a keyboard hotkey, before it emits a REBOOT pulse.
- Outputs spi_addr and REBOOT straight to the sequencer's inputs.

Parameters:
- DEFAULT_ADDR, 24'h058000: spi_addr reset value; also the address used by a hotkey reboot.
- REG_BASE, 8'h40: index of ADDR_L. ADDR_M = REG_BASE+1, ADDR_H = REG_BASE+2, CTRL = REG_BASE+3.
- PULSE_LEN, 8: cycles REBOOT is held high (legal range 1..255).
- UNLOCK_TIMEOUT, 255: cycles the ARMED state waits for the trigger write (legal range 1..255).

Ports:
- CLK  in  1  system clock, same clock as the sequencer.
- RESET  in  1  asynchronous, active-high reset.
- cpu_a  in  16  Z80 address bus.
- cpu_d_in  in  8  Z80 data to the block.
- cpu_d_out  out  8  readback data.
- cpu_d_oe  out  1  readback drive enable.
- cpu_iorq_n  in  1  Z80 IORQ, active low, asynchronous.
- cpu_wr_n  in  1  Z80 WR, active low, asynchronous.
- cpu_rd_n  in  1  Z80 RD, active low, asynchronous.
- key_reboot  in  1  hotkey level from keyboard decoder, asynchronous.
- spi_addr  out  24  boot address to the sequencer.
- REBOOT  out  1  reboot request to the sequencer.
- busy  out  1  high in ARMED, PULSE or DONE.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - spi_addr = DEFAULT_ADDR, index register = 8'h00, REBOOT = 0, busy = 0, cpu_d_out = 0, cpu_d_oe = 0;
  - state = IDLE, all counters = 0, all synchronisers = 0.
- Strobe synchronisation:
  - wr_s = ~iorq_n & ~wr_n and rd_s = ~iorq_n & ~rd_n, each through a 2-FF synchroniser.
  - A write event is the rising edge of synchronised wr_s: exactly one CLK cycle, at most once per Z80 I/O cycle.
  - cpu_a and cpu_d_in are sampled on the event cycle; they are stable through the Z80 write.
  - key_reboot has its own 2-FF synchroniser; the key event is its rising edge.
- Write decode:
  - cpu_a == 0xFC3B: index register <= cpu_d_in.
  - cpu_a == 0xFD3B with index == ADDR_L/M/H: write spi_addr[7:0] / [15:8] / [23:16].
  - Address writes are ignored outside IDLE.
  - Any other index or address is ignored.
- State machine:
  - IDLE:
    - CTRL write of 0x5A -> ARMED, timeout counter cleared.
    - Other CTRL values -> stay in IDLE.
  - ARMED:
    - Counter increments every cycle.
    - CTRL write of 0xA5 -> PULSE.
    - Any other CTRL write -> IDLE.
    - Counter reaching UNLOCK_TIMEOUT -> IDLE.
    - Writes to ADDR_x while ARMED are ignored and do not cancel ARMED.
  - PULSE:
    - REBOOT = 1 from the first cycle in PULSE.
    - Stays exactly PULSE_LEN cycles, then -> DONE with REBOOT = 0.
    - The sequencer acts on the falling edge of REBOOT.
  - DONE:
    - Terminal until RESET; configuration is replaced anyway.
    - All further CPU and key events are ignored.
- Hotkey: a key event in IDLE or ARMED loads spi_addr <= DEFAULT_ADDR and enters PULSE on the next cycle.
- Simultaneous key event and CTRL 0xA5 write in one cycle: key wins and spi_addr = DEFAULT_ADDR.
- spi_addr is frozen from PULSE entry onward; it is stable before REBOOT rises and while the sequencer consumes it.
- Latency:
  - write event -> REBOOT high: 1 cycle;
  - key event -> REBOOT high: 1 cycle.
  - Pin to event is an additional 2 cycles of synchroniser delay.
- RESET mid-PULSE: REBOOT drops immediately (asynchronous). The sequencer then sees a falling edge; the team accepts this, since system reset is a reboot condition anyway.

Optional Feature:
- MULTIBOOT_READBACK_EN defined:
  - While synchronised rd_s is high and cpu_a == 0xFD3B, the block drives cpu_d_oe = 1.
  - cpu_d_out is registered by one cycle and returns:
    - ADDR_L/M/H: the corresponding spi_addr byte;
    - CTRL: {5'b0, state==DONE, state==PULSE, state==ARMED};
    - other indexes: 0xFF.
  - cpu_a == 0xFC3B reads return the index register.
- Undefined: cpu_d_oe = 0 and cpu_d_out = 0 constantly, and no read logic is built.

Decomposition:
- Package multiboot_pkg holds:
  - port addresses 0xFC3B/0xFD3B;
  - register offsets;
  - unlock/trigger codes 0x5A/0xA5;
  - the state enum IDLE/ARMED/PULSE/DONE.
- One sub-module: sync_edge, a 2-FF synchroniser plus rising-edge detector, used three times (wr, rd, key).

Test Plan:
- Reset, then read ADDR_L/M/H with readback enabled -> 0x00, 0x80, 0x05; REBOOT = 0; busy = 0.
- Write ADDR 0x0B0000 (0x00, 0x00, 0x0B), then CTRL 0x5A, then CTRL 0xA5 -> spi_addr = 0x0B0000; REBOOT high exactly 8 cycles; busy stays 1 afterwards; later writes ignored.
- CTRL 0x5A then no write for 256 cycles, then CTRL 0xA5 -> no REBOOT; state back in IDLE after 255 cycles.
- CTRL 0x5A, then CTRL 0x33, then CTRL 0xA5 -> no REBOOT (0x33 returns to IDLE).
- ADDR set to 0x098000, then key_reboot rises coincident with the trigger write event -> spi_addr = 0x058000, one 8-cycle REBOOT pulse.
- RESET asserted on cycle 3 of PULSE -> REBOOT = 0 and spi_addr = DEFAULT_ADDR the same cycle; state IDLE.
